// File: rtl/counter_check_pkg.sv
// Shared types and default parameters for the counter sequence checker.
package counter_check_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam int DEF_WIDTH         = 8;
   localparam int DEF_LOCK_CYCLES   = 4;
   localparam int DEF_UNLOCK_ERRORS = 2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_resetb,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_resetb)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_inc && (r_cnt != '1))
         r_cnt <= r_cnt + W'(1);
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/counter_8bit_seq_checker.sv
// Receive-side monitor for a free-running up-counter: locks onto the +1 sequence,
// then flags breaks and counts errors and good wraps. All outputs are registered.
module counter_8bit_seq_checker
   import counter_check_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int LOCK_CYCLES   = DEF_LOCK_CYCLES,
   parameter int UNLOCK_ERRORS = DEF_UNLOCK_ERRORS,
   parameter int ERR_W         = 8,
   parameter int WRAP_W        = 16
) (
   input  logic              i_clk,
   input  logic              i_resetb,
   input  logic              i_enable,
   input  logic              i_clear_stats,
   input  logic [WIDTH-1:0]  i_count_in,
   output logic              o_locked,
   output logic              o_error_pulse,
   output logic              o_wrap_pulse,
   output logic [WIDTH-1:0]  o_expected,
   output logic [ERR_W-1:0]  o_err_count,
   output logic [WRAP_W-1:0] o_wrap_count
);

   localparam int GW = $clog2(LOCK_CYCLES + 1);
   localparam int BW = $clog2(UNLOCK_ERRORS + 1);

   state_t              r_state;
   logic [WIDTH-1:0]    r_prev;
   logic [WIDTH-1:0]    r_expected;
   logic [GW-1:0]       r_good_run;
   logic [BW-1:0]       r_bad_run;
   logic                r_locked;
   logic                r_error_pulse;
   logic                r_wrap_pulse;
   logic [WRAP_W-1:0]   r_wrap_count;

   logic                w_match;
   logic                w_wrap;
   logic                w_lock_err;

   assign w_match    = (i_count_in == r_prev + WIDTH'(1));
   assign w_wrap     = (r_prev == '1) && (i_count_in == '0);
   assign w_lock_err = i_enable && (r_state == LOCKED) && !w_match;

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .i_clk    (i_clk),
      .i_resetb (i_resetb),
      .i_clr    (i_clear_stats),
      .i_inc    (w_lock_err),
      .o_cnt    (o_err_count)
   );

   always_ff @(posedge i_clk) begin
      if (!i_resetb) begin
         r_state       <= IDLE;
         r_prev        <= '0;
         r_expected    <= '0;
         r_good_run    <= '0;
         r_bad_run     <= '0;
         r_locked      <= 1'b0;
         r_error_pulse <= 1'b0;
         r_wrap_pulse  <= 1'b0;
         r_wrap_count  <= '0;
      end else begin
         r_error_pulse <= 1'b0;
         r_wrap_pulse  <= 1'b0;
         if (i_clear_stats)
            r_wrap_count <= '0;

         if (!i_enable) begin
            r_state    <= IDLE;
            r_locked   <= 1'b0;
            r_good_run <= '0;
            r_bad_run  <= '0;
         end else begin
            r_prev     <= i_count_in;
            r_expected <= i_count_in + WIDTH'(1);
            case (r_state)
               IDLE: r_state <= ACQUIRE;
               ACQUIRE: begin
                  if (w_match) begin
                     r_good_run <= r_good_run + GW'(1);
                     if (r_good_run == GW'(LOCK_CYCLES - 1)) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                     end
                  end else begin
                     r_good_run <= '0;
                  end
               end
               LOCKED: begin
                  if (!w_match) begin
                     r_error_pulse <= 1'b1;
                     // Enough consecutive misses: fall back and re-acquire from scratch.
                     if (r_bad_run == BW'(UNLOCK_ERRORS - 1)) begin
                        r_state    <= ACQUIRE;
                        r_locked   <= 1'b0;
                        r_good_run <= '0;
                        r_bad_run  <= '0;
                     end else begin
                        r_bad_run <= r_bad_run + BW'(1);
                     end
                  end else begin
                     r_bad_run <= '0;
                     if (w_wrap) begin
                        r_wrap_pulse <= 1'b1;
                        if (!i_clear_stats)
                           r_wrap_count <= r_wrap_count + WRAP_W'(1);
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign o_locked      = r_locked;
   assign o_error_pulse = r_error_pulse;
   assign o_wrap_pulse  = r_wrap_pulse;
   assign o_expected    = r_expected;
   assign o_wrap_count  = r_wrap_count;

endmodule

// File: tb/tb_counter_8bit_seq_checker.sv
// Directed bench: three checkers (UNLOCK_ERRORS = 2, 1, 400) share one stimulus stream.
module tb_counter_8bit_seq_checker;

   logic       clk = 1'b0;
   logic       resetb;
   logic       enable;
   logic       clear_stats;
   logic [7:0] count_in;

   logic       lk [3];
   logic       ep [3];
   logic       wp [3];
   logic [7:0] ex [3];
   logic [7:0] ec [3];
   logic [15:0] wc [3];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   counter_8bit_seq_checker #(.UNLOCK_ERRORS(2)) dut (
      .i_clk(clk), .i_resetb(resetb), .i_enable(enable), .i_clear_stats(clear_stats),
      .i_count_in(count_in), .o_locked(lk[0]), .o_error_pulse(ep[0]), .o_wrap_pulse(wp[0]),
      .o_expected(ex[0]), .o_err_count(ec[0]), .o_wrap_count(wc[0]));

   counter_8bit_seq_checker #(.UNLOCK_ERRORS(1)) dut_u1 (
      .i_clk(clk), .i_resetb(resetb), .i_enable(enable), .i_clear_stats(clear_stats),
      .i_count_in(count_in), .o_locked(lk[1]), .o_error_pulse(ep[1]), .o_wrap_pulse(wp[1]),
      .o_expected(ex[1]), .o_err_count(ec[1]), .o_wrap_count(wc[1]));

   counter_8bit_seq_checker #(.UNLOCK_ERRORS(400)) dut_big (
      .i_clk(clk), .i_resetb(resetb), .i_enable(enable), .i_clear_stats(clear_stats),
      .i_count_in(count_in), .o_locked(lk[2]), .o_error_pulse(ep[2]), .o_wrap_pulse(wp[2]),
      .o_expected(ex[2]), .o_err_count(ec[2]), .o_wrap_count(wc[2]));

   // Apply one sample, let it be clocked, and settle away from the edge.
   task automatic step(input logic [7:0] v);
      count_in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetb = 1'b0; enable = 1'b0; clear_stats = 1'b0;
      step(8'h00);
      resetb = 1'b1; enable = 1'b1;
   endtask

   // IDLE load plus four good increments: locked afterwards, prev = base+4.
   task automatic lock_at(input logic [7:0] base);
      for (int k = 0; k < 5; k++) step(base + 8'(k));
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (lk[0] !== 1'b0) $display("FAIL rst_locked: got %0b want 0", lk[0]); else n_pass++;
      n_chk++; if (ep[0] !== 1'b0) $display("FAIL rst_err_pulse: got %0b want 0", ep[0]); else n_pass++;
      n_chk++; if (wp[0] !== 1'b0) $display("FAIL rst_wrap_pulse: got %0b want 0", wp[0]); else n_pass++;
      n_chk++; if (ex[0] !== 8'h00) $display("FAIL rst_expected: got %h want 00", ex[0]); else n_pass++;
      n_chk++; if (ec[0] !== 8'h00) $display("FAIL rst_err_count: got %h want 00", ec[0]); else n_pass++;
      n_chk++; if (wc[0] !== 16'h0) $display("FAIL rst_wrap_count: got %h want 0000", wc[0]); else n_pass++;
   endtask

   task automatic test_lock();
      do_reset();
      step(8'h10);
      n_chk++; if (ex[0] !== 8'h11) $display("FAIL lock_exp_first: got %h want 11", ex[0]); else n_pass++;
      step(8'h11); step(8'h12); step(8'h13);
      n_chk++; if (lk[0] !== 1'b0) $display("FAIL lock_early: got %0b want 0", lk[0]); else n_pass++;
      step(8'h14);
      n_chk++; if (lk[0] !== 1'b1) $display("FAIL lock_after_14: got %0b want 1", lk[0]); else n_pass++;
      n_chk++; if (ep[0] !== 1'b0) $display("FAIL lock_no_err: got %0b want 0", ep[0]); else n_pass++;
      n_chk++; if (ex[0] !== 8'h15) $display("FAIL lock_expected: got %h want 15", ex[0]); else n_pass++;
   endtask

   task automatic test_single_error();
      do_reset();
      lock_at(8'h1B);
      step(8'h20);
      n_chk++; if (ep[0] !== 1'b0) $display("FAIL err1_pre: got %0b want 0", ep[0]); else n_pass++;
      step(8'h22);
      n_chk++; if (ep[0] !== 1'b1) $display("FAIL err1_pulse: got %0b want 1", ep[0]); else n_pass++;
      n_chk++; if (ec[0] !== 8'd1) $display("FAIL err1_count: got %0d want 1", ec[0]); else n_pass++;
      n_chk++; if (lk[0] !== 1'b1) $display("FAIL err1_locked: got %0b want 1", lk[0]); else n_pass++;
      step(8'h23);
      n_chk++; if (ep[0] !== 1'b0) $display("FAIL err1_pulse_end: got %0b want 0", ep[0]); else n_pass++;
      n_chk++; if (lk[0] !== 1'b1) $display("FAIL err1_still_locked: got %0b want 1", lk[0]); else n_pass++;
   endtask

   task automatic test_wrap();
      do_reset();
      lock_at(8'hF9);
      step(8'hFE); step(8'hFF);
      n_chk++; if (wp[0] !== 1'b0) $display("FAIL wrap_pre: got %0b want 0", wp[0]); else n_pass++;
      step(8'h00);
      n_chk++; if (wp[0] !== 1'b1) $display("FAIL wrap_pulse: got %0b want 1", wp[0]); else n_pass++;
      n_chk++; if (wc[0] !== 16'd1) $display("FAIL wrap_count: got %0d want 1", wc[0]); else n_pass++;
      n_chk++; if (ep[0] !== 1'b0) $display("FAIL wrap_no_err: got %0b want 0", ep[0]); else n_pass++;
      step(8'h01);
      n_chk++; if (wp[0] !== 1'b0) $display("FAIL wrap_pulse_end: got %0b want 0", wp[0]); else n_pass++;
      n_chk++; if (ec[0] !== 8'd0) $display("FAIL wrap_err_count: got %0d want 0", ec[0]); else n_pass++;
   endtask

   task automatic test_counter_reset();
      do_reset();
      lock_at(8'h33);
      step(8'h00);
      n_chk++; if (ep[1] !== 1'b1) $display("FAIL crst_pulse: got %0b want 1", ep[1]); else n_pass++;
      n_chk++; if (lk[1] !== 1'b0) $display("FAIL crst_unlock: got %0b want 0", lk[1]); else n_pass++;
      n_chk++; if (wp[1] !== 1'b0) $display("FAIL crst_no_wrap: got %0b want 0", wp[1]); else n_pass++;
      n_chk++; if (lk[0] !== 1'b1) $display("FAIL crst_u2_locked: got %0b want 1", lk[0]); else n_pass++;
      step(8'h01); step(8'h02); step(8'h03);
      n_chk++; if (lk[1] !== 1'b0) $display("FAIL crst_relock_early: got %0b want 0", lk[1]); else n_pass++;
      step(8'h04);
      n_chk++; if (lk[1] !== 1'b1) $display("FAIL crst_relock: got %0b want 1", lk[1]); else n_pass++;
   endtask

   task automatic test_saturation();
      do_reset();
      lock_at(8'h4B);
      step(8'h50);
      for (int k = 1; k <= 300; k++) begin
         step(8'h50);
         if (k == 255) begin
            n_chk++; if (ec[2] !== 8'hFF) $display("FAIL sat_255: got %h want ff", ec[2]); else n_pass++;
         end
         if (k == 256) begin
            n_chk++; if (ec[2] !== 8'hFF) $display("FAIL sat_256: got %h want ff", ec[2]); else n_pass++;
         end
      end
      n_chk++; if (ec[2] !== 8'hFF) $display("FAIL sat_300: got %h want ff", ec[2]); else n_pass++;
      n_chk++; if (lk[2] !== 1'b1) $display("FAIL sat_locked: got %0b want 1", lk[2]); else n_pass++;
      clear_stats = 1'b1;
      step(8'h50);
      clear_stats = 1'b0;
      n_chk++; if (ec[2] !== 8'h00) $display("FAIL clr_count: got %h want 00", ec[2]); else n_pass++;
      n_chk++; if (ep[2] !== 1'b1) $display("FAIL clr_pulse: got %0b want 1", ep[2]); else n_pass++;
   endtask

   task automatic test_midreset_enable();
      do_reset();
      lock_at(8'h60);
      step(8'h70); step(8'h71);
      resetb = 1'b0;
      step(8'h72);
      resetb = 1'b1;
      n_chk++; if (lk[0] !== 1'b0) $display("FAIL mrst_locked: got %0b want 0", lk[0]); else n_pass++;
      n_chk++; if (ec[0] !== 8'h00) $display("FAIL mrst_err_count: got %h want 00", ec[0]); else n_pass++;
      n_chk++; if (ex[0] !== 8'h00) $display("FAIL mrst_expected: got %h want 00", ex[0]); else n_pass++;
      n_chk++; if (ep[0] !== 1'b0) $display("FAIL mrst_pulse: got %0b want 0", ep[0]); else n_pass++;
      lock_at(8'h80);
      step(8'h90); step(8'h91);
      enable = 1'b0;
      step(8'hAA); step(8'hAA);
      n_chk++; if (lk[0] !== 1'b0) $display("FAIL dis_locked: got %0b want 0", lk[0]); else n_pass++;
      n_chk++; if (ec[0] !== 8'd1) $display("FAIL dis_err_held: got %0d want 1", ec[0]); else n_pass++;
      n_chk++; if (ex[0] !== 8'h92) $display("FAIL dis_exp_held: got %h want 92", ex[0]); else n_pass++;
      enable = 1'b1;
      step(8'hA0); step(8'hA1); step(8'hA2); step(8'hA3);
      n_chk++; if (lk[0] !== 1'b0) $display("FAIL en_relock_early: got %0b want 0", lk[0]); else n_pass++;
      step(8'hA4);
      n_chk++; if (lk[0] !== 1'b1) $display("FAIL en_relock: got %0b want 1", lk[0]); else n_pass++;
      n_chk++; if (ec[0] !== 8'd1) $display("FAIL en_err_kept: got %0d want 1", ec[0]); else n_pass++;
   endtask

   initial begin
      resetb = 1'b0; enable = 1'b0; clear_stats = 1'b0; count_in = 8'h00;
      #1;
      test_reset();
      test_lock();
      test_single_error();
      test_wrap();
      test_counter_reset();
      test_saturation();
      test_midreset_enable();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
